// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational magnitude/negation helper: two's-complement negate when neg is set.
module muldiv_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] val,
  input  logic             neg,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = neg ? (~val + WIDTH'(1)) : val;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply in the MUL state.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int unsigned      WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] DIV0_LO = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               signed_op, sign_a, sign_b, accept, last_iter, in_flight;
  logic [WIDTH-1:0]   mag_a, mag_b, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]     trial;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign sign_a    = signed_op & src_a[WIDTH-1];
  assign sign_b    = signed_op & src_b[WIDTH-1];
  assign in_flight = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
  assign accept    = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start && !cancel;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_a (.val(src_a), .neg(sign_a), .res(mag_a));
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_b (.val(src_b), .neg(sign_b), .res(mag_b));
  muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (.val(acc_q), .neg(neg_res_q), .res(prod_fix));
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (.val(acc_q[WIDTH-1:0]), .neg(neg_res_q), .res(quo_fix));
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (.val(acc_q[2*WIDTH-1:WIDTH]), .neg(neg_rem_q), .res(rem_fix));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      is_div_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      is_div_q  <= is_div_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: state_d = accept ? (op[1] ? ST_DIV : ST_MUL) : ST_IDLE;
`ifdef MULDIV_FAST_MUL_EN
      ST_MUL:           state_d = ST_FIX;
`else
      ST_MUL:           if (last_iter) state_d = ST_FIX;
`endif
      ST_DIV:           if (last_iter) state_d = ST_FIX;
      ST_FIX:           state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
    if (cancel && in_flight) state_d = ST_IDLE;
  end

  always_comb begin
    busy = in_flight;
    done = (state_q == ST_DONE);
    hi   = hi_q;
    lo   = lo_q;
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    is_div_d  = is_div_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    trial     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};

    case (state_q)
      ST_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
        acc_d = (2*WIDTH)'(acc_q[WIDTH-1:0]) * (2*WIDTH)'(opnd_q);
`else
        logic [WIDTH:0] add_sum;
        add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
        acc_d   = {add_sum, acc_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
`endif
      end
      ST_DIV: begin
        if (!trial[WIDTH]) acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else               acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
      end
      ST_FIX: begin
        if (!cancel) begin
          if (is_div_q) begin
            lo_d = div0_q ? DIV0_LO : quo_fix;
            hi_d = rem_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: ;
    endcase

    if (accept) begin
      cnt_d     = '0;
      is_div_d  = op[1];
      neg_res_d = sign_a ^ sign_b;
      neg_rem_d = sign_a;
      div0_d    = (src_b == '0);
      acc_d     = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
      opnd_d    = op[1] ? mag_b : mag_a;
    end

    // MTHI/MTLO take priority over a same-edge commit
    if (hi_we) hi_d = wr_data;
    if (lo_we) lo_d = wr_data;
  end

endmodule
